aes_block_scheduler: RTL and testbench

//   Sequences multi-block AES-128 decryption: fetches ciphertext blocks from the ciphertext memory, launches
//   the AES core once per block, collects each plaintext result and writes it to plaintext memory.

---
 rtl/aes_block_scheduler_pkg.sv | 19 +
 rtl/aes_sched_watchdog.sv | 31 +++
 rtl/aes_block_scheduler.sv | 164 ++++++++++++++++
 tb/tb_aes_block_scheduler.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_block_scheduler_pkg.sv
// Shared types and defaults for the multi-block AES decryption scheduler.
// Holds the 3-bit FSM state encoding and default sizing/watchdog limits.
package aes_block_scheduler_pkg;

    localparam int unsigned TEXT_WIDTH_DEF = 128;
    localparam int unsigned ADDR_WIDTH_DEF = 8;
    localparam int unsigned BLOCK_CNT_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF    = 64;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_LAUNCH  = 3'd3,
        S_RUN     = 3'd4,
        S_STORE   = 3'd5
    } state_e;

endpackage

// File: rtl/aes_sched_watchdog.sv
// Per-block watchdog: counts enabled cycles since the last clear.
// Ports: clk, rst_n (async low), clear, en; expire pulses on the TIMEOUT-th enabled cycle.
module aes_sched_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    logic [CW-1:0] count;

    // Fires while the current enabled cycle is the TIMEOUT-th one; 0 disables.
    assign expire = (TIMEOUT != 0) && en && (count == CW'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !expire) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/aes_block_scheduler.sv
// Fetches ciphertext blocks, launches the AES core per block and stores plaintext.
// Ports: clk_i/rst_ni, start_i; rd_* ciphertext memory; core_* AES core handshake;
// wr_* plaintext memory; busy_o, done_o/error_o (sticky), blk_cnt_o blocks stored.
module aes_block_scheduler
    import aes_block_scheduler_pkg::*;
#(
    parameter int unsigned TEXT_WIDTH = TEXT_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned BLOCK_CNT  = BLOCK_CNT_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [TEXT_WIDTH-1:0] rd_data_i,
    output logic                  core_start_o,
    output logic [TEXT_WIDTH-1:0] core_text_o,
    input  logic                  core_done_i,
    input  logic [TEXT_WIDTH-1:0] core_result_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [TEXT_WIDTH-1:0] wr_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   blk_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BLOCK_CNT - 1);

    state_e                state;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [ADDR_WIDTH-1:0] rd_addr_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [TEXT_WIDTH-1:0] text_nxt;
    logic [TEXT_WIDTH-1:0] result_nxt;
    logic [ADDR_WIDTH:0]   blk_cnt_nxt;
    logic                  rd_en_nxt;
    logic                  core_start_nxt;
    logic                  wr_en_nxt;
    logic                  done_nxt;
    logic                  error_nxt;
    logic                  wd_clear;
    logic                  wd_en;
    logic                  wd_expire;

    // Core result arriving on the expiry cycle wins: count only without done.
    assign wd_clear = (state == S_LAUNCH);
    assign wd_en    = (state == S_RUN) && !core_done_i;

    aes_sched_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clear (wd_clear),
        .en    (wd_en),
        .expire(wd_expire)
    );

    // Outputs are registered from the next-state decode so strobes line up
    // with the state they belong to.
    always_comb begin
        state_nxt      = state;
        addr_nxt       = addr;
        rd_addr_nxt    = rd_addr_o;
        wr_addr_nxt    = wr_addr_o;
        text_nxt       = core_text_o;
        result_nxt     = wr_data_o;
        blk_cnt_nxt    = blk_cnt_o;
        done_nxt       = done_o;
        error_nxt      = error_o;
        rd_en_nxt      = 1'b0;
        core_start_nxt = 1'b0;
        wr_en_nxt      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i) begin
                    done_nxt    = 1'b0;
                    error_nxt   = 1'b0;
                    blk_cnt_nxt = '0;
                    addr_nxt    = '0;
                    rd_addr_nxt = '0;
                    rd_en_nxt   = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                text_nxt       = rd_data_i;
                core_start_nxt = 1'b1;
                state_nxt      = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_done_i) begin
                    result_nxt  = core_result_i;
                    wr_addr_nxt = addr;
                    wr_en_nxt   = 1'b1;
                    blk_cnt_nxt = blk_cnt_o + (ADDR_WIDTH + 1)'(1);
                    state_nxt   = S_STORE;
                end else if (wd_expire) begin
                    error_nxt = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_STORE: begin
                if (addr == LAST) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    addr_nxt    = addr + ADDR_WIDTH'(1);
                    rd_addr_nxt = addr + ADDR_WIDTH'(1);
                    rd_en_nxt   = 1'b1;
                    state_nxt   = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            addr         <= '0;
            rd_en_o      <= 1'b0;
            rd_addr_o    <= '0;
            core_start_o <= 1'b0;
            core_text_o  <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
            blk_cnt_o    <= '0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            rd_en_o      <= rd_en_nxt;
            rd_addr_o    <= rd_addr_nxt;
            core_start_o <= core_start_nxt;
            core_text_o  <= text_nxt;
            wr_en_o      <= wr_en_nxt;
            wr_addr_o    <= wr_addr_nxt;
            wr_data_o    <= result_nxt;
            busy_o       <= (state_nxt != S_IDLE);
            done_o       <= done_nxt;
            error_o      <= error_nxt;
            blk_cnt_o    <= blk_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Bench for aes_block_scheduler: memory + core models, write scoreboard.
// Instance 0 runs 4 blocks per start, instance 1 runs a single block.
module tb_aes_block_scheduler;

    localparam int TW = 128;
    localparam int AW = 8;
    localparam logic [TW-1:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [TW-1:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    // Stand-in decryption: plaintext = ciphertext ^ KEY, so CT0 decrypts to PT0.
    localparam logic [TW-1:0] KEY = CT0 ^ PT0;

    typedef struct {
        int            addr;
        logic [TW-1:0] data;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start      [2];
    logic          rd_en      [2];
    logic [AW-1:0] rd_addr    [2];
    logic [TW-1:0] rd_data    [2];
    logic          core_start [2];
    logic [TW-1:0] core_text  [2];
    logic          core_done  [2];
    logic [TW-1:0] core_result[2];
    logic          wr_en      [2];
    logic [AW-1:0] wr_addr    [2];
    logic [TW-1:0] wr_data    [2];
    logic          busy       [2];
    logic          done       [2];
    logic          error      [2];
    logic [AW:0]   blk_cnt    [2];

    logic [TW-1:0] mem [2][4];
    int            lat       [2];
    int            pend      [2];
    logic          mdl_done  [2];
    logic          force_done[2];
    logic          inj       [2];
    logic          inj_fetch;
    int            nstart    [2];
    int            cyc;
    wr_t           wq0[$];
    wr_t           wq1[$];
    int            rq0[$];
    int            passed = 0;
    int            total  = 0;

    always #5 clk = ~clk;

    assign core_done[0] = mdl_done[0] | force_done[0] | inj[0];
    assign core_done[1] = mdl_done[1] | force_done[1] | inj[1];

    aes_block_scheduler #(
        .TEXT_WIDTH(TW), .ADDR_WIDTH(AW), .BLOCK_CNT(4), .TIMEOUT(64)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]),
        .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
        .core_start_o(core_start[0]), .core_text_o(core_text[0]),
        .core_done_i(core_done[0]), .core_result_i(core_result[0]),
        .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]),
        .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]),
        .blk_cnt_o(blk_cnt[0])
    );

    aes_block_scheduler #(
        .TEXT_WIDTH(TW), .ADDR_WIDTH(AW), .BLOCK_CNT(1), .TIMEOUT(64)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]),
        .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
        .core_start_o(core_start[1]), .core_text_o(core_text[1]),
        .core_done_i(core_done[1]), .core_result_i(core_result[1]),
        .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]),
        .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]),
        .blk_cnt_o(blk_cnt[1])
    );

    function automatic logic [TW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit outs_zero(int k);
        return {rd_en[k], rd_addr[k], core_start[k], core_text[k], wr_en[k],
                wr_addr[k], wr_data[k], busy[k], done[k], error[k],
                blk_cnt[k]} === '0;
    endfunction

    // Ciphertext memory: data only valid the cycle after a read strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rd_data[k] <= rd_en[k] ? mem[k][rd_addr[k][1:0]] : rnd128();
        end
    end

    // Core model and write/read monitors, evaluated just after each edge.
    initial begin
        cyc = 0;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            mdl_done[k] = 1'b0;
            inj[k] = 1'b0;
            nstart[k] = 0;
            core_result[k] = '0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < 2; k++) begin
                mdl_done[k] = 1'b0;
                if (!rst_n) begin
                    pend[k] = 0;
                end else begin
                    if (pend[k] > 0) begin
                        pend[k]--;
                        if (pend[k] == 0) mdl_done[k] = 1'b1;
                    end
                    if (core_start[k]) begin
                        nstart[k]++;
                        if (lat[k] > 0) pend[k] = lat[k];
                    end
                end
                core_result[k] = mdl_done[k] ? (core_text[k] ^ KEY) : rnd128();
                inj[k] = inj_fetch && rd_en[k];
            end
            if (wr_en[0]) wq0.push_back('{int'(wr_addr[0]), wr_data[0], cyc});
            if (wr_en[1]) wq1.push_back('{int'(wr_addr[1]), wr_data[1], cyc});
            if (rd_en[0]) rq0.push_back(int'(rd_addr[0]));
        end
    end

    task automatic clear_logs();
        wq0.delete();
        wq1.delete();
        rq0.delete();
        nstart[0] = 0;
        nstart[1] = 0;
    endtask

    task automatic pulse_start(input int k, output int s);
        @(negedge clk);
        start[k] = 1'b1;
        s = cyc;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget,
                             output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (!busy[k]) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int bad;
        #2;
        total++;
        if (!outs_zero(0)) $display("FAIL reset_out0 busy=%b done=%b", busy[0], done[0]);
        else passed++;
        total++;
        if (!outs_zero(1)) $display("FAIL reset_out1 busy=%b done=%b", busy[1], done[1]);
        else passed++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!outs_zero(0) || !outs_zero(1)) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL idle_quiet nonzero_cycles=%0d required=0", bad);
        else passed++;
    endtask

    task automatic test_single();
        int s, at;
        bit ok;
        clear_logs();
        mem[1][0] = CT0;
        lat[1] = 10;
        pulse_start(1, s);
        wait_idle(1, 200, ok, at);
        total++;
        if (!ok) $display("FAIL single_timeout busy stuck");
        else passed++;
        total++;
        if (wq1.size() != 1) $display("FAIL single_writes got=%0d required=1", wq1.size());
        else passed++;
        if (wq1.size() >= 1) begin
            total++;
            if (wq1[0].addr != 0 || wq1[0].data !== PT0)
                $display("FAIL single_data addr=%0d data=%h required 0/%h",
                         wq1[0].addr, wq1[0].data, PT0);
            else passed++;
            total++;
            if (wq1[0].cyc - s != 14)
                $display("FAIL single_latency got=%0d required=14", wq1[0].cyc - s);
            else passed++;
        end
        total++;
        if (done[1] !== 1'b1 || error[1] !== 1'b0 || blk_cnt[1] !== 9'd1)
            $display("FAIL single_status done=%b err=%b cnt=%0d required 1/0/1",
                     done[1], error[1], blk_cnt[1]);
        else passed++;
    endtask

    task automatic test_multi();
        int s, at, l;
        bit ok;
        repeat (2) begin
            clear_logs();
            for (int a = 0; a < 4; a++) mem[0][a] = rnd128();
            l = $urandom_range(1, 20);
            lat[0] = l;
            pulse_start(0, s);
            wait_idle(0, 4 * (4 + l) + 50, ok, at);
            total++;
            if (!ok || at != s + 4 * (4 + l) + 1)
                $display("FAIL multi_end lat=%0d at=%0d required=%0d", l, at - s, 4 * (4 + l) + 1);
            else passed++;
            total++;
            if (rq0.size() != 4 || wq0.size() != 4 || nstart[0] != 4)
                $display("FAIL multi_counts reads=%0d writes=%0d starts=%0d required 4/4/4",
                         rq0.size(), wq0.size(), nstart[0]);
            else passed++;
            for (int i = 0; i < 4 && i < wq0.size() && i < rq0.size(); i++) begin
                total++;
                if (rq0[i] != i || wq0[i].addr != i || wq0[i].data !== (mem[0][i] ^ KEY)
                    || wq0[i].cyc != s + (i + 1) * (4 + l))
                    $display("FAIL multi_blk%0d rd=%0d wr=%0d data=%h cyc=%0d required %0d/%0d/%h/%0d",
                             i, rq0[i], wq0[i].addr, wq0[i].data, wq0[i].cyc - s,
                             i, i, mem[0][i] ^ KEY, (i + 1) * (4 + l));
                else passed++;
            end
            total++;
            if (done[0] !== 1'b1 || error[0] !== 1'b0 || blk_cnt[0] !== 9'd4)
                $display("FAIL multi_status done=%b err=%b cnt=%0d required 1/0/4",
                         done[0], error[0], blk_cnt[0]);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        int s, at;
        bit ok;
        clear_logs();
        lat[0] = 0;
        pulse_start(0, s);
        wait_idle(0, 200, ok, at);
        total++;
        if (!ok || at != s + 68)
            $display("FAIL wd_expiry at=%0d required=68", at - s);
        else passed++;
        total++;
        if (error[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0 || wq0.size() != 0)
            $display("FAIL wd_status err=%b done=%b busy=%b writes=%0d required 1/0/0/0",
                     error[0], done[0], busy[0], wq0.size());
        else passed++;
        // Result on the very expiry cycle must still be stored.
        clear_logs();
        lat[0] = 64;
        pulse_start(0, s);
        wait_idle(0, 600, ok, at);
        total++;
        if (!ok || wq0.size() != 4 || error[0] !== 1'b0 || done[0] !== 1'b1 || blk_cnt[0] !== 9'd4)
            $display("FAIL wd_coincident writes=%0d err=%b done=%b cnt=%0d required 4/0/1/4",
                     wq0.size(), error[0], done[0], blk_cnt[0]);
        else passed++;
        if (wq0.size() >= 1) begin
            total++;
            if (wq0[0].addr != 0 || wq0[0].data !== (mem[0][0] ^ KEY))
                $display("FAIL wd_coincident_data addr=%0d data=%h", wq0[0].addr, wq0[0].data);
            else passed++;
        end
        clear_logs();
        lat[0] = 65;
        pulse_start(0, s);
        wait_idle(0, 200, ok, at);
        total++;
        if (!ok || error[0] !== 1'b1 || wq0.size() != 0 || at != s + 68)
            $display("FAIL wd_late err=%b writes=%0d at=%0d required 1/0/68",
                     error[0], wq0.size(), at - s);
        else passed++;
    endtask

    task automatic test_ignore();
        int s, c, at;
        bit ok;
        clear_logs();
        lat[0] = 10;
        for (int a = 0; a < 4; a++) mem[0][a] = rnd128();
        repeat (3) begin
            @(negedge clk);
            force_done[0] = 1'b1;
            @(negedge clk);
            force_done[0] = 1'b0;
        end
        total++;
        if (busy[0] !== 1'b0 || wq0.size() != 0 || error[0] !== 1'b1)
            $display("FAIL ign_idle_done busy=%b writes=%0d err=%b required 0/0/1",
                     busy[0], wq0.size(), error[0]);
        else passed++;
        inj_fetch = 1'b1;
        pulse_start(0, s);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            c = cyc - s;
            start[0] = (c == 5 || c == 20 || c == 33);
            if (!busy[0]) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        start[0] = 1'b0;
        inj_fetch = 1'b0;
        total++;
        if (!ok || at != s + 57 || wq0.size() != 4 || nstart[0] != 4)
            $display("FAIL ign_counts at=%0d writes=%0d starts=%0d required 57/4/4",
                     at - s, wq0.size(), nstart[0]);
        else passed++;
        for (int i = 0; i < 4 && i < wq0.size(); i++) begin
            total++;
            if (wq0[i].addr != i || wq0[i].data !== (mem[0][i] ^ KEY) || wq0[i].cyc != s + (i + 1) * 14)
                $display("FAIL ign_blk%0d addr=%0d data=%h cyc=%0d", i, wq0[i].addr,
                         wq0[i].data, wq0[i].cyc - s);
            else passed++;
        end
        repeat (5) @(negedge clk);
        total++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b1 || error[0] !== 1'b0 || blk_cnt[0] !== 9'd4)
            $display("FAIL ign_status busy=%b done=%b err=%b cnt=%0d required 0/1/0/4",
                     busy[0], done[0], error[0], blk_cnt[0]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int s, at;
        bit ok, hit;
        clear_logs();
        lat[0] = 10;
        pulse_start(0, s);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (core_start[0] && rd_addr[0] == 8'd2) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) $display("FAIL rst_mid_reach block2 launch not seen");
        else passed++;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!outs_zero(0) || !outs_zero(1))
            $display("FAIL rst_async busy=%b done=%b rd_en=%b", busy[0], done[0], rd_en[0]);
        else passed++;
        total++;
        if (wq0.size() != 2) $display("FAIL rst_prior_writes got=%0d required=2", wq0.size());
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        pulse_start(0, s);
        wait_idle(0, 200, ok, at);
        total++;
        if (!ok || rq0.size() != 4 || wq0.size() != 4)
            $display("FAIL rst_rerun reads=%0d writes=%0d required 4/4", rq0.size(), wq0.size());
        else passed++;
        if (rq0.size() >= 1 && wq0.size() >= 1) begin
            total++;
            if (rq0[0] != 0 || wq0[0].addr != 0 || wq0[0].data !== (mem[0][0] ^ KEY))
                $display("FAIL rst_first rd=%0d wr=%0d data=%h required 0/0/%h",
                         rq0[0], wq0[0].addr, wq0[0].data, mem[0][0] ^ KEY);
            else passed++;
        end
        total++;
        if (done[0] !== 1'b1 || blk_cnt[0] !== 9'd4)
            $display("FAIL rst_status done=%b cnt=%0d required 1/4", done[0], blk_cnt[0]);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        force_done[0] = 1'b0;
        force_done[1] = 1'b0;
        inj_fetch = 1'b0;
        lat[0] = 0;
        lat[1] = 0;
        for (int a = 0; a < 4; a++) begin
            mem[0][a] = '0;
            mem[1][a] = '0;
        end
        #1;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1);
    end

endmodule
